// File: rtl/doorlock_seq_ctrl.sv
// Keypad door-lock sequencer: digit entry, compare, open/fail/lockout, code change.
// Ports: key_press/key_code in, change_mode, match in; user_we/user_digit/user_clr,
// code_we/code_out, open_o/fail_o/change_o/lockout_o, digit_cnt out.
module doorlock_seq_ctrl #(
  parameter int DIGITS      = 4,
  parameter int HOLD_CYC    = 50_000_000,
  parameter int TIMEOUT_CYC = 250_000_000,
  parameter int LOCK_CYC    = 500_000_000,
  parameter int MAX_FAIL    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_press,
  input  logic [3:0]  key_code,
  input  logic        change_mode,
  input  logic        match,
  output logic        user_we,
  output logic [3:0]  user_digit,
  output logic        user_clr,
  output logic        code_we,
  output logic [15:0] code_out,
  output logic        open_o,
  output logic        fail_o,
  output logic        change_o,
  output logic        lockout_o,
  output logic [2:0]  digit_cnt
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYC - 1);
  localparam logic [FW-1:0] FMAX      = FW'(MAX_FAIL);
  localparam logic [2:0]    DIG       = 3'(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_SETTLE, S_CHECK,
    S_OPEN, S_FAIL, S_LOCK, S_CHANGE
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [3:0]    dig_q, dig_d;
  logic          clr_q, clr_d;
  logic          cwe_q, cwe_d;
  logic [15:0]   code_q, code_d;
  logic [15:0]   buf_q, buf_d;
  logic          open_q, open_d;
  logic          fail_q, fail_d;
  logic          chg_q, chg_d;
  logic          lock_q, lock_d;
  logic [2:0]    dcnt_q, dcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] to_q, to_d;
  logic [LW-1:0] lk_q, lk_d;
  logic          key_ok;

  // Codes above 9 are not digits and never count as keys.
  assign key_ok = key_press && (key_code <= 4'd9);

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    dig_d   = dig_q;
    clr_d   = 1'b0;
    cwe_d   = 1'b0;
    code_d  = code_q;
    buf_d   = buf_q;
    dcnt_d  = dcnt_q;
    fcnt_d  = fcnt_q;
    hold_d  = '0;
    to_d    = '0;
    lk_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (key_ok) begin
          we_d    = 1'b1;
          dig_d   = key_code;
          dcnt_d  = 3'd1;
          state_d = (DIGITS == 1) ? S_SETTLE : S_ENTRY;
        end
      end
      S_ENTRY: begin
        // A key in the expiry cycle wins over the timeout.
        if (key_ok) begin
          we_d   = 1'b1;
          dig_d  = key_code;
          dcnt_d = dcnt_q + 3'd1;
          if (dcnt_q + 3'd1 == DIG) state_d = S_SETTLE;
        end else if (to_q == TO_LAST) begin
          clr_d   = 1'b1;
          dcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        if (match && change_mode) begin
          state_d = S_CHANGE;
          clr_d   = 1'b1;
          dcnt_d  = '0;
          buf_d   = '0;
          fcnt_d  = '0;
        end else if (match) begin
          state_d = S_OPEN;
          fcnt_d  = '0;
        end else begin
          state_d = S_FAIL;
          if (fcnt_q != FMAX) fcnt_d = fcnt_q + 1'b1;
        end
      end
      S_OPEN, S_FAIL: begin
        if (hold_q == HOLD_LAST) begin
          clr_d   = 1'b1;
          dcnt_d  = '0;
          state_d = (state_q == S_FAIL && fcnt_q == FMAX) ? S_LOCK : S_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_LOCK: begin
        if (lk_q == LOCK_LAST) begin
          fcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          lk_d = lk_q + 1'b1;
        end
      end
      S_CHANGE: begin
        if (key_ok) begin
          for (int i = 0; i < 4; i++)
            if (dcnt_q == 3'(i)) buf_d[15-4*i -: 4] = key_code;
          dcnt_d = dcnt_q + 3'd1;
          if (dcnt_q + 3'd1 == DIG) begin
            cwe_d   = 1'b1;
            code_d  = buf_d;
            buf_d   = '0;
            dcnt_d  = '0;
            state_d = S_IDLE;
          end
        end else if (to_q == TO_LAST) begin
          buf_d   = '0;
          dcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Indications track the state they belong to, one register stage later.
    open_d = (state_d == S_OPEN);
    fail_d = (state_d == S_FAIL);
    chg_d  = (state_d == S_CHANGE);
    lock_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      dig_q   <= '0;
      clr_q   <= 1'b0;
      cwe_q   <= 1'b0;
      code_q  <= '0;
      buf_q   <= '0;
      open_q  <= 1'b0;
      fail_q  <= 1'b0;
      chg_q   <= 1'b0;
      lock_q  <= 1'b0;
      dcnt_q  <= '0;
      fcnt_q  <= '0;
      hold_q  <= '0;
      to_q    <= '0;
      lk_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      dig_q   <= dig_d;
      clr_q   <= clr_d;
      cwe_q   <= cwe_d;
      code_q  <= code_d;
      buf_q   <= buf_d;
      open_q  <= open_d;
      fail_q  <= fail_d;
      chg_q   <= chg_d;
      lock_q  <= lock_d;
      dcnt_q  <= dcnt_d;
      fcnt_q  <= fcnt_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      lk_q    <= lk_d;
    end
  end

  assign user_we    = we_q;
  assign user_digit = dig_q;
  assign user_clr   = clr_q;
  assign code_we    = cwe_q;
  assign code_out   = code_q;
  assign open_o     = open_q;
  assign fail_o     = fail_q;
  assign change_o   = chg_q;
  assign lockout_o  = lock_q;
  assign digit_cnt  = dcnt_q;

endmodule

// File: tb/tb_doorlock_seq_ctrl.sv
// Directed bench for doorlock_seq_ctrl with a shadow user/stored register bank.
// The comparator result is derived from the shadow registers.
module tb_doorlock_seq_ctrl;

  localparam int DIGITS = 4;
  localparam int HOLD   = 8;
  localparam int TMO    = 20;
  localparam int LOCK   = 30;
  localparam int MAXF   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_press, change_mode, match;
  logic [3:0]  key_code;
  logic        user_we, user_clr, code_we;
  logic [3:0]  user_digit;
  logic [15:0] code_out;
  logic        open_o, fail_o, change_o, lockout_o;
  logic [2:0]  digit_cnt;

  doorlock_seq_ctrl #(
    .DIGITS(DIGITS), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO),
    .LOCK_CYC(LOCK), .MAX_FAIL(MAXF)
  ) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .key_code(key_code),
    .change_mode(change_mode), .match(match),
    .user_we(user_we), .user_digit(user_digit), .user_clr(user_clr),
    .code_we(code_we), .code_out(code_out),
    .open_o(open_o), .fail_o(fail_o), .change_o(change_o),
    .lockout_o(lockout_o), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] ush, stored;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ush    <= '0;
      stored <= 16'h1234;
    end else begin
      if (user_clr)     ush <= '0;
      else if (user_we) ush <= {ush[11:0], user_digit};
      if (code_we) stored <= code_out;
    end
  end
  assign match = (ush == stored);

  int n_we = 0, n_cwe = 0;
  always @(posedge clk) begin
    if (user_we) n_we++;
    if (code_we) n_cwe++;
  end

  logic [29:0] all_o;
  assign all_o = {user_we, user_digit, user_clr, code_we, code_out,
                  open_o, fail_o, change_o, lockout_o, digit_cnt};

  int n_chk = 0, n_fail = 0;
  int n0, c0, nl;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key_press = 1'b1;
    key_code  = d;
    tick();
    key_press = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic enter(input logic [15:0] code, input string tag);
    logic [3:0] d;
    for (int i = 0; i < DIGITS; i++) begin
      d = code[15-4*i -: 4];
      if (i > 0) tick();
      press(d);
      chk({tag, " key"}, {user_we, user_digit, digit_cnt},
          {1'b1, d, 3'(i + 1)});
    end
  endtask

  task automatic result(input string tag, input bit is_fail,
                        input bit lock_exp);
    int n;
    bit other;
    n = 0;
    other = 1'b0;
    tick();
    chk({tag, " pre"}, {open_o, fail_o}, 2'b00);
    tick();
    for (int i = 0; i < HOLD; i++) begin
      if (is_fail ? fail_o : open_o) n++;
      if (is_fail ? open_o : fail_o) other = 1'b1;
      tick();
    end
    chk({tag, " hold"}, n, HOLD);
    chk({tag, " other"}, 32'(other), 0);
    chk({tag, " end"}, {open_o, fail_o, user_clr, digit_cnt, lockout_o},
        {1'b0, 1'b0, 1'b1, 3'd0, lock_exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    key_press   = 1'b0;
    key_code    = 4'd0;
    change_mode = 1'b0;
    tick();
    tick();
    chk("reset", all_o, 0);
    rst = 1'b0;
    tick();

    press(4'd12);
    chk("badkey", {user_we, digit_cnt}, 0);
    tick();

    enter(16'h1234, "open1");
    result("open1", 1'b0, 1'b0);

    tick();
    press(4'd1);
    chk("to k1", {user_we, digit_cnt}, {1'b1, 3'd1});
    repeat (TMO - 1) tick();
    chk("to pre1", {user_clr, digit_cnt}, {1'b0, 3'd1});
    press(4'd2);
    chk("to edge key", {user_we, user_clr, digit_cnt},
        {1'b1, 1'b0, 3'd2});
    repeat (TMO - 1) tick();
    chk("to pre2", {user_clr, digit_cnt}, {1'b0, 3'd2});
    tick();
    chk("to fire", {user_clr, digit_cnt, fail_o}, {1'b1, 3'd0, 1'b0});
    tick();
    chk("to idle", {user_we, user_clr, fail_o}, 0);
    enter(16'h1234, "open2");
    result("open2", 1'b0, 1'b0);

    for (int k = 0; k < MAXF; k++) begin
      tick();
      enter(16'h9999, "bad");
      result("bad", 1'b1, k == MAXF - 1);
    end
    n0 = n_we;
    nl = 0;
    for (int i = 0; i < LOCK; i++) begin
      if (lockout_o) nl++;
      key_press = (i % 4 == 1);
      key_code  = 4'd5;
      tick();
    end
    key_press = 1'b0;
    chk("lock len", nl, LOCK);
    chk("lock end", {lockout_o, user_we}, 0);
    chk("lock nowe", n_we - n0, 0);
    tick();
    enter(16'h1234, "open3");
    result("open3", 1'b0, 1'b0);

    tick(); enter(16'h9999, "f1"); result("f1", 1'b1, 1'b0);
    tick(); enter(16'h9999, "f2"); result("f2", 1'b1, 1'b0);
    tick(); enter(16'h1234, "o4"); result("o4", 1'b0, 1'b0);
    tick(); enter(16'h9999, "f3"); result("f3", 1'b1, 1'b0);

    tick();
    change_mode = 1'b1;
    enter(16'h1234, "chg1");
    tick();
    tick();
    chk("chg1 entry", {change_o, user_clr, digit_cnt},
        {1'b1, 1'b1, 3'd0});
    change_mode = 1'b0;
    n0 = n_we;
    c0 = n_cwe;
    tick();
    press(4'd5);
    chk("chg1 k5", {change_o, user_we, digit_cnt}, {1'b1, 1'b0, 3'd1});
    tick();
    press(4'd6);
    chk("chg1 k6", {change_o, user_we, digit_cnt}, {1'b1, 1'b0, 3'd2});
    repeat (TMO - 1) tick();
    chk("chg1 pre to", {change_o, digit_cnt}, {1'b1, 3'd2});
    tick();
    chk("chg1 to", {change_o, digit_cnt, code_we}, 0);
    chk("chg1 nocwe", n_cwe - c0, 0);
    chk("chg1 nowe", n_we - n0, 0);
    tick();
    enter(16'h1234, "open5");
    result("open5", 1'b0, 1'b0);

    tick();
    press(4'd1); tick();
    press(4'd2); tick();
    press(4'd3);
    chk("pre rst", {user_we, digit_cnt}, {1'b1, 3'd3});
    #2 rst = 1'b1;
    #1 chk("rst entry", all_o, 0);
    #2 rst = 1'b0;
    tick();
    enter(16'h1234, "open6");
    repeat (4) tick();
    chk("open mid", open_o, 1);
    #2 rst = 1'b1;
    #1 chk("rst open", all_o, 0);
    #2 rst = 1'b0;
    tick();
    enter(16'h1234, "open7");
    result("open7", 1'b0, 1'b0);

    tick();
    change_mode = 1'b1;
    enter(16'h1234, "chg2");
    tick();
    tick();
    chk("chg2 entry", {change_o, user_clr, digit_cnt},
        {1'b1, 1'b1, 3'd0});
    change_mode = 1'b0;
    n0 = n_we;
    c0 = n_cwe;
    for (int i = 0; i < DIGITS; i++) begin
      tick();
      press(4'(5 + i));
      if (i < DIGITS - 1)
        chk("chg2 key", {change_o, user_we, code_we, digit_cnt},
            {1'b1, 1'b0, 1'b0, 3'(i + 1)});
    end
    chk("commit", {code_we, code_out, change_o, digit_cnt, user_we},
        {1'b1, 16'h5678, 1'b0, 3'd0, 1'b0});
    tick();
    chk("commit once", code_we, 0);
    chk("commit cnt", n_cwe - c0, 1);
    chk("chg2 nowe", n_we - n0, 0);
    tick();
    enter(16'h5678, "open8");
    result("open8", 1'b0, 1'b0);
    tick();
    enter(16'h1234, "oldcode");
    result("oldcode", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
